// File: rtl/riscv_loader_pkg.sv
// Shared state encoding, error codes and core debug constants for the program loader.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [2:0] HALT_CODE_DEFAULT = 3'b100;

endpackage

// File: rtl/riscv_prog_loader_timeout_ctr.sv
// Clearable, enabled up-counter that saturates at TIMEOUT_CYCLES-1 and flags it.
module loader_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/riscv_prog_loader.sv
// Loads a framed byte stream into core instruction memory, runs the core and captures its result.
// Optional trailing XOR checksum byte enabled by defining RISCV_LOADER_CHECKSUM_EN.
module riscv_prog_loader
    import riscv_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 4,
    parameter int         DATA_WIDTH     = 8,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [2:0] HALT_CODE      = HALT_CODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  core_hold,
    input  logic [2:0]            core_state,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int MAX_LEN = 1 << ADDR_WIDTH;
    localparam int CW      = ADDR_WIDTH + 1;

    loader_state_e state, state_nx;
    logic [CW-1:0] len_q, idx_q;
    logic          accept, len_ok, last_byte, halted, tmo, is_len_state;

    assign is_len_state = (state == ST_LEN) || (state == ST_DONE) || (state == ST_ERR);
    // s_ready is held low while rst is asserted even though state already reads LEN
    assign s_ready   = !rst && (is_len_state || state == ST_DATA || state == ST_CSUM);
    assign accept    = s_valid && s_ready;
    assign len_ok    = (s_data != '0) && (32'(s_data) <= 32'(MAX_LEN));
    assign last_byte = (idx_q + CW'(1) == len_q);
    assign halted    = (core_state == HALT_CODE);
    assign core_hold = !((state == ST_START) || (state == ST_RUN));

`ifdef RISCV_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  csum_ok;

    assign csum_ok = (s_data == csum_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= '0;
        else if (accept && is_len_state)
            csum_q <= '0;
        else if (accept && state == ST_DATA)
            csum_q <= csum_q ^ s_data;
    end
`endif

    loader_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_START),
        .en  (state == ST_RUN),
        .tc  (tmo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_LEN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_LEN, ST_DONE, ST_ERR:
                if (accept) state_nx = len_ok ? ST_DATA : ST_ERR;
            ST_DATA:
                if (accept && last_byte) begin
`ifdef RISCV_LOADER_CHECKSUM_EN
                    state_nx = ST_CSUM;
`else
                    state_nx = ST_START;
`endif
                end
`ifdef RISCV_LOADER_CHECKSUM_EN
            ST_CSUM:
                if (accept) state_nx = csum_ok ? ST_START : ST_ERR;
`endif
            ST_START:
                state_nx = ST_RUN;
            ST_RUN:
                // halt wins over a timeout landing in the same cycle
                if (halted)   state_nx = ST_DONE;
                else if (tmo) state_nx = ST_ERR;
            default:
                state_nx = ST_LEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            idx_q     <= '0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            result    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            prog_we <= 1'b0;
            case (state)
                ST_LEN, ST_DONE, ST_ERR:
                    if (accept) begin
                        done     <= 1'b0;
                        len_q    <= s_data[CW-1:0];
                        idx_q    <= '0;
                        err      <= !len_ok;
                        err_code <= len_ok ? ERR_NONE : ERR_LEN;
                    end
                ST_DATA:
                    if (accept) begin
                        prog_we   <= 1'b1;
                        prog_addr <= idx_q[ADDR_WIDTH-1:0];
                        prog_data <= s_data;
                        idx_q     <= idx_q + CW'(1);
                    end
`ifdef RISCV_LOADER_CHECKSUM_EN
                ST_CSUM:
                    if (accept && !csum_ok) begin
                        err      <= 1'b1;
                        err_code <= ERR_CSUM;
                    end
`endif
                ST_RUN:
                    if (halted) begin
                        result <= core_result;
                        done   <= 1'b1;
                    end else if (tmo) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_prog_loader.sv
// Self-checking bench for riscv_prog_loader: vector table, hand sequences and random frames vs. a frame-level model.
module tb_riscv_prog_loader;
    localparam int         AW   = 4;
    localparam int         DW   = 8;
    localparam int         T    = 40;
    localparam int         MAXL = 1 << AW;
    localparam logic [2:0] HALT = 3'b100;

    logic          clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
    logic [DW-1:0] s_data = '0, core_result = '0;
    logic [2:0]    core_state = 3'b000;
    logic          s_ready, prog_we, core_hold, done, err;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data, result;
    logic [1:0]    err_code;

    int errors = 0, checks = 0;
    logic [DW-1:0] last_res = '0;

    always #5 clk = ~clk;

    riscv_prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .HALT_CODE(HALT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .core_hold(core_hold), .core_state(core_state), .core_result(core_result),
        .result(result), .done(done), .err(err), .err_code(err_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: a write must appear exactly one cycle after each accepted data byte.
    logic [AW+DW-1:0] wq[$];
    logic prev_acc = 1'b0, data_phase = 1'b0;
    always @(negedge clk) begin
        if (rst) prev_acc = 1'b0;
        else begin
            if (prev_acc || prog_we) chk("write_latency", prog_we, prev_acc);
            if (prog_we) wq.push_back({prog_addr, prog_data});
            prev_acc = s_valid && s_ready && data_phase;
        end
    end

    task automatic chk_edge();
        @(negedge clk); #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        int n = 0;
        s_valid = 1'b1; s_data = b;
        @(negedge clk);
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        if (!s_ready) chk("send_stalled", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = DW'($urandom);
    endtask

    task automatic do_frame(input logic [DW-1:0] len, input logic [DW-1:0] d[$], input int gap,
                            input logic bad_csum, output bit loaded);
        logic [DW-1:0] x = '0;
        logic [AW+DW-1:0] exp_w[$];
        loaded = 1'b0;
        @(posedge clk); #1;
        wq.delete();
        send_byte(len);
        chk_edge();
        chk("len_clears_done", done, 0);
        if (len == 0 || int'(len) > MAXL) begin
            chk("len_err", err, 1); chk("len_err_code", err_code, 1);
            chk("len_hold", core_hold, 1); chk("len_no_writes", wq.size(), 0);
            chk("len_result_kept", result, last_res);
            return;
        end
        chk("len_ok_err", err, 0);
        @(posedge clk); #1;
        data_phase = 1'b1;
        foreach (d[i]) begin
            repeat (gap) begin @(posedge clk); #1; end
            send_byte(d[i]);
            x ^= d[i];
            exp_w.push_back({AW'(i), d[i]});
        end
        data_phase = 1'b0;
`ifdef RISCV_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (x ^ 8'h01) : x);
`endif
        chk_edge();
        chk("wr_count", wq.size(), exp_w.size());
        foreach (exp_w[i]) if (i < wq.size()) chk("wr_addr_data", wq[i], exp_w[i]);
`ifdef RISCV_LOADER_CHECKSUM_EN
        if (bad_csum) begin
            chk("csum_err", err, 1); chk("csum_code", err_code, 2); chk("csum_hold", core_hold, 1);
            return;
        end
`endif
        chk("start_hold_low", core_hold, 0);
        chk("start_err", err, 0);
        loaded = 1'b1;
    endtask

    // Called in the START cycle. halt_k=0: never halt; otherwise HALT is seen in RUN cycle halt_k.
    task automatic run_core(input int halt_k, input logic [DW-1:0] res);
        if (halt_k == 0) begin
            repeat (T) @(negedge clk);
            #1;
            chk("run_last_hold", core_hold, 0); chk("run_last_err", err, 0);
            chk_edge();
            chk("tmo_err", err, 1); chk("tmo_code", err_code, 3);
            chk("tmo_hold", core_hold, 1); chk("tmo_done", done, 0);
            chk("tmo_result_kept", result, last_res);
        end else begin
            repeat (halt_k) @(posedge clk);
            #1;
            core_state = HALT; core_result = res;
            chk_edge();
            chk("run_hold", core_hold, 0); chk("run_done", done, 0);
            chk_edge();
            core_state = 3'b000; core_result = DW'($urandom);
            chk("halt_done", done, 1); chk("halt_result", result, res);
            chk("halt_hold", core_hold, 1); chk("halt_err", err, 0);
            last_res = res;
            chk_edge();
            chk("result_held", result, res);
        end
    endtask

    task automatic reset_pulse(input logic in_run);
        @(negedge clk); #2;
        if (in_run) chk("pre_rst_hold", core_hold, 0);
        rst = 1'b1; #1;
        chk("arst_we", prog_we, 0); chk("arst_hold", core_hold, 1); chk("arst_done", done, 0);
        chk("arst_err", err, 0); chk("arst_ready", s_ready, 0); chk("arst_result", result, 0);
        @(negedge clk); #2;
        rst = 1'b0;
        last_res = '0;
        chk_edge();
        chk("post_rst_ready", s_ready, 1); chk("post_rst_hold", core_hold, 1);
    endtask

    typedef struct {
        logic [DW-1:0] len, b0, b1, b2;
        int            gap, halt_k;
        logic [DW-1:0] res;
        logic [1:0]    code;
        logic          dn;
    } vec_t;

    vec_t vt[9];

    initial begin
        automatic logic [DW-1:0] q[$];
        automatic bit ld;
        vt[0] = '{8'h03, 8'h41, 8'h0A, 8'hC8, 0, 2,  8'h2A, 2'd0, 1'b1};
        vt[1] = '{8'h01, 8'h80, 8'h00, 8'h00, 0, 1,  8'h5C, 2'd0, 1'b1};
        vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  8'h00, 2'd1, 1'b0};
        vt[3] = '{8'h11, 8'h00, 8'h00, 8'h00, 0, 0,  8'h00, 2'd1, 1'b0};
        vt[4] = '{8'h10, 8'h12, 8'h34, 8'h56, 1, 7,  8'hE1, 2'd0, 1'b1};
        vt[5] = '{8'h01, 8'h33, 8'h00, 8'h00, 0, 0,  8'h00, 2'd3, 1'b0};
        vt[6] = '{8'h02, 8'h11, 8'h22, 8'h00, 0, T,  8'h99, 2'd0, 1'b1};
        vt[7] = '{8'hFF, 8'h00, 8'h00, 8'h00, 0, 0,  8'h00, 2'd1, 1'b0};
        vt[8] = '{8'h10, 8'hA5, 8'h5A, 8'hFF, 0, 1,  8'h01, 2'd0, 1'b1};

        #2;
        chk("rst_ready", s_ready, 0); chk("rst_we", prog_we, 0); chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0); chk("rst_hold", core_hold, 1); chk("rst_result", result, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_code", err_code, 0);
        @(negedge clk); #2;
        rst = 1'b0;
        chk_edge();
        chk("idle_ready", s_ready, 1);

        foreach (vt[v]) begin
            q.delete();
            if (vt[v].len != 0 && int'(vt[v].len) <= MAXL)
                for (int i = 0; i < int'(vt[v].len); i++)
                    q.push_back(i == 0 ? vt[v].b0 : i == 1 ? vt[v].b1 : i == 2 ? vt[v].b2 : DW'($urandom));
            do_frame(vt[v].len, q, vt[v].gap, 1'b0, ld);
            if (ld) run_core(vt[v].halt_k, vt[v].res);
            chk("vec_code", err_code, vt[v].code);
            chk("vec_done", done, vt[v].dn);
        end

`ifdef RISCV_LOADER_CHECKSUM_EN
        q = {8'h5A, 8'h0F};
        do_frame(8'h02, q, 0, 1'b0, ld);
        chk("csum_good_loaded", ld, 1);
        if (ld) run_core(3, 8'h11);
        do_frame(8'h02, q, 0, 1'b1, ld);
        repeat (5) begin chk_edge(); chk("csum_bad_hold", core_hold, 1); end
`endif

        // Async reset in RUN, then in DONE.
        q = {8'h77};
        do_frame(8'h01, q, 0, 1'b0, ld);
        repeat (2) @(negedge clk);
        reset_pulse(1'b1);
        do_frame(8'h01, q, 0, 1'b0, ld);
        if (ld) run_core(4, 8'hC3);
        reset_pulse(1'b0);

        for (int r = 0; r < 25; r++) begin
            automatic int len = $urandom_range(0, MAXL + 2);
            automatic int hk  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T);
            q.delete();
            if (len >= 1 && len <= MAXL)
                for (int i = 0; i < len; i++) q.push_back(DW'($urandom));
            do_frame(DW'(len), q, $urandom_range(0, 2), 1'b0, ld);
            if (ld) run_core(hk, DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
